// File: rtl/exposure_timer.sv
// Exposure-time register with button handling, exposure overflow (ovf5) and
// row-read slot overflow (ovf4) generation for the capture sequencer.
module exposure_timer #(
    parameter int EXP_W        = 5,
    parameter int EXP_MIN      = 2,
    parameter int EXP_MAX      = 30,
    parameter int EXP_DEFAULT  = 15,
    parameter int TICKS_PER_MS = 1,
    parameter int READ_LEN     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             exp_increase,
    input  logic             exp_decrease,
    input  logic             start_count,
    input  logic             count_read,
    output logic             ovf5,
    output logic             ovf4,
    output logic [EXP_W-1:0] exp_time,
    output logic             busy
);

    // state   | meaning
    // E_IDLE  | waiting for start_count, counters held at 0
    // E_COUNT | counting ms up to the latched exposure time
    // E_DONE  | exposure elapsed, ovf5 held while start_count stays high
    typedef enum logic [1:0] {E_IDLE, E_COUNT, E_DONE} e_state_t;

    localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int RD_W   = $clog2(READ_LEN);

    localparam logic [EXP_W-1:0]  EXP_MIN_V  = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0]  EXP_MAX_V  = EXP_W'(EXP_MAX);
    localparam logic [EXP_W-1:0]  EXP_DEF_V  = EXP_W'(EXP_DEFAULT);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_MS - 1);
    localparam logic [RD_W-1:0]   RD_LAST    = RD_W'(READ_LEN - 1);

    e_state_t          state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [EXP_W-1:0]  ms_cnt_q, ms_cnt_d;
    logic [EXP_W-1:0]  exp_lat_q, exp_lat_d;
    logic [EXP_W-1:0]  exp_time_q, exp_time_d;
    logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic              ovf5_q, ovf5_d;
    logic              ovf4_q, ovf4_d;
    logic              busy_q, busy_d;
    logic              inc_prev_q, inc_prev_d;
    logic              dec_prev_q, dec_prev_d;

    logic             inc_edge, dec_edge;
    logic             tick_wrap, ms_done, rd_last;
    logic [EXP_W-1:0] ms_inc;

    assign inc_edge  = exp_increase & ~inc_prev_q;
    assign dec_edge  = exp_decrease & ~dec_prev_q;
    assign tick_wrap = (tick_cnt_q == TICK_LAST);
    assign ms_inc    = ms_cnt_q + EXP_W'(1);
    assign ms_done   = tick_wrap && (ms_inc == exp_lat_q);
    assign rd_last   = (rd_cnt_q == RD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= E_IDLE;
            tick_cnt_q <= '0;
            ms_cnt_q   <= '0;
            exp_lat_q  <= '0;
            exp_time_q <= EXP_DEF_V;
            rd_cnt_q   <= '0;
            ovf5_q     <= 1'b0;
            ovf4_q     <= 1'b0;
            busy_q     <= 1'b0;
            inc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            ms_cnt_q   <= ms_cnt_d;
            exp_lat_q  <= exp_lat_d;
            exp_time_q <= exp_time_d;
            rd_cnt_q   <= rd_cnt_d;
            ovf5_q     <= ovf5_d;
            ovf4_q     <= ovf4_d;
            busy_q     <= busy_d;
            inc_prev_q <= inc_prev_d;
            dec_prev_q <= dec_prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!start_count) begin
            state_d = E_IDLE;
        end else begin
            case (state_q)
                E_IDLE:  state_d = E_COUNT;
                E_COUNT: if (ms_done) state_d = E_DONE;
                E_DONE:  state_d = E_DONE;
                default: state_d = E_IDLE;
            endcase
        end
    end

    // Exposure counters; dropping start_count from any state clears everything.
    always_comb begin
        tick_cnt_d = '0;
        ms_cnt_d   = '0;
        exp_lat_d  = exp_lat_q;
        ovf5_d     = 1'b0;
        if (start_count) begin
            case (state_q)
                E_IDLE: exp_lat_d = exp_time_q;
                E_COUNT: begin
                    tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + TICK_W'(1);
                    ms_cnt_d   = tick_wrap ? ms_inc : ms_cnt_q;
                    ovf5_d     = ms_done;
                end
                E_DONE:  ovf5_d = 1'b1;
                default: ovf5_d = 1'b0;
            endcase
        end
    end

    // Read slot counter wraps on its last count so back-to-back slots have no gap.
    always_comb begin
        rd_cnt_d = '0;
        ovf4_d   = 1'b0;
        if (count_read) begin
            rd_cnt_d = rd_last ? '0 : rd_cnt_q + RD_W'(1);
            ovf4_d   = rd_last;
        end
    end

    always_comb begin
        busy_d     = start_count | count_read;
        inc_prev_d = exp_increase;
        dec_prev_d = exp_decrease;
        exp_time_d = exp_time_q;
        if (!busy_q) begin
            if (inc_edge && !dec_edge) begin
                exp_time_d = (exp_time_q >= EXP_MAX_V) ? EXP_MAX_V : exp_time_q + EXP_W'(1);
            end else if (dec_edge && !inc_edge) begin
                exp_time_d = (exp_time_q <= EXP_MIN_V) ? EXP_MIN_V : exp_time_q - EXP_W'(1);
            end
        end
    end

    assign ovf5     = ovf5_q;
    assign ovf4     = ovf4_q;
    assign exp_time = exp_time_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_exposure_timer.sv
// Bench for exposure_timer: directed scenarios plus randomized traffic, all
// checked every cycle against a run-length based reference model.
module tb_exposure_timer;

    localparam int EXP_W        = 5;
    localparam int EXP_MIN      = 2;
    localparam int EXP_MAX      = 30;
    localparam int EXP_DEFAULT  = 15;
    localparam int TICKS_PER_MS = 1;
    localparam int READ_LEN     = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             exp_increase = 1'b0;
    logic             exp_decrease = 1'b0;
    logic             start_count = 1'b0;
    logic             count_read = 1'b0;
    logic             ovf5, ovf4, busy;
    logic [EXP_W-1:0] exp_time;

    exposure_timer #(
        .EXP_W(EXP_W), .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX),
        .EXP_DEFAULT(EXP_DEFAULT), .TICKS_PER_MS(TICKS_PER_MS), .READ_LEN(READ_LEN)
    ) dut (
        .clk(clk), .reset(reset),
        .exp_increase(exp_increase), .exp_decrease(exp_decrease),
        .start_count(start_count), .count_read(count_read),
        .ovf5(ovf5), .ovf4(ovf4), .exp_time(exp_time), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: tracks how many consecutive edges each input was high.
    int m_exp, m_inc_prev, m_dec_prev, m_busy;
    int m_sc_run, m_cr_run, m_lat, m_ovf5, m_ovf4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_exp = EXP_DEFAULT;
        m_inc_prev = 0; m_dec_prev = 0; m_busy = 0;
        m_sc_run = 0; m_cr_run = 0; m_lat = 0; m_ovf5 = 0; m_ovf4 = 0;
    endtask

    task automatic model_step(input int i, input int d, input int s, input int c);
        int ei, ed, old_exp;
        ei = i & ~m_inc_prev;
        ed = d & ~m_dec_prev;
        old_exp = m_exp;
        if (m_busy == 0) begin
            if (ei == 1 && ed == 0) m_exp = (m_exp + 1 > EXP_MAX) ? EXP_MAX : m_exp + 1;
            else if (ed == 1 && ei == 0) m_exp = (m_exp - 1 < EXP_MIN) ? EXP_MIN : m_exp - 1;
        end
        m_inc_prev = i;
        m_dec_prev = d;
        m_busy = s | c;
        if (s == 1) begin
            if (m_sc_run == 0) m_lat = old_exp;
            m_sc_run++;
        end else begin
            m_sc_run = 0;
        end
        m_ovf5 = (s == 1 && m_sc_run > m_lat * TICKS_PER_MS) ? 1 : 0;
        m_cr_run = (c == 1) ? m_cr_run + 1 : 0;
        m_ovf4 = (c == 1 && (m_cr_run % READ_LEN) == 0) ? 1 : 0;
    endtask

    task automatic check_outputs();
        check("exp_time", 32'(exp_time), m_exp);
        check("ovf5", 32'(ovf5), m_ovf5);
        check("ovf4", 32'(ovf4), m_ovf4);
        check("busy", 32'(busy), m_busy);
    endtask

    task automatic drive_cycle(input bit i, input bit d, input bit s, input bit c);
        @(negedge clk);
        exp_increase = i; exp_decrease = d; start_count = s; count_read = c;
        @(posedge clk);
        model_step(int'(i), int'(d), int'(s), int'(c));
        #1;
        check_outputs();
    endtask

    // Asserted between edges so its effect must be visible without a clock.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_exp_time", 32'(exp_time), EXP_DEFAULT);
        check("rst_ovf5", 32'(ovf5), 0);
        check("rst_ovf4", 32'(ovf4), 0);
        check("rst_busy", 32'(busy), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic set_exp(input int target);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        for (int n = 0; n < 64 && m_exp != target; n++) begin
            if (m_exp < target) drive_cycle(1, 0, 0, 0);
            else drive_cycle(0, 1, 0, 0);
            drive_cycle(0, 0, 0, 0);
        end
        check("set_exp", 32'(exp_time), target);
    endtask

    task automatic press(input bit i, input bit d);
        drive_cycle(i, d, 0, 0);
        drive_cycle(i, d, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
    endtask

    initial begin
        int fs, exp_cyc, rd_cyc;
        bit r_sc, r_cr;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state and idle
        for (int k = 0; k < 5; k++) drive_cycle(0, 0, 0, 0);
        check("idle_exp", 32'(exp_time), EXP_DEFAULT);

        // Reset mid-exposure
        for (int k = 0; k < 8; k++) drive_cycle(0, 0, 1, 0);
        apply_reset();
        for (int k = 0; k < 4; k++) drive_cycle(0, 0, 0, 0);
        check("rst_abort_exp", 32'(exp_time), 15);

        // Button stepping and saturation
        press(1, 0); check("inc1", 32'(exp_time), 16);
        press(1, 0); check("inc2", 32'(exp_time), 17);
        press(1, 0); check("inc3", 32'(exp_time), 18);
        for (int k = 0; k < 20; k++) press(1, 0);
        check("sat_max", 32'(exp_time), EXP_MAX);
        for (int k = 0; k < 40; k++) press(0, 1);
        check("sat_min", 32'(exp_time), EXP_MIN);
        set_exp(10);
        press(1, 1);
        check("both_edges", 32'(exp_time), 10);
        for (int k = 0; k < 6; k++) drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        check("held_once", 32'(exp_time), 11);

        // Exposure with locked-out button press
        set_exp(5);
        for (int k = 0; k < 9; k++) begin
            drive_cycle(k == 2, 0, 1, 0);
            check("exp5_ovf5", 32'(ovf5), (k >= 5) ? 1 : 0);
        end
        drive_cycle(0, 0, 0, 0);
        check("exp5_drop", 32'(ovf5), 0);
        check("exp5_locked", 32'(exp_time), 5);

        // Abort then full restart
        set_exp(10);
        for (int k = 0; k < 4; k++) drive_cycle(0, 0, 1, 0);
        for (int k = 0; k < 2; k++) drive_cycle(0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            drive_cycle(0, 0, 1, 0);
            check("restart_ovf5", 32'(ovf5), (k >= 10) ? 1 : 0);
        end
        drive_cycle(0, 0, 0, 0);

        // Read slot pulses
        for (int k = 0; k < 8; k++) begin
            drive_cycle(0, 0, 0, 1);
            check("rd_ovf4", 32'(ovf4), (k == 3 || k == 7) ? 1 : 0);
        end
        drive_cycle(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) drive_cycle(0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            drive_cycle(0, 0, 0, 1);
            check("rd_reraise", 32'(ovf4), (k == 3) ? 1 : 0);
        end
        drive_cycle(0, 0, 0, 0);

        // Closed loop with a minimal capture sequencer
        set_exp(3);
        fs = 1; exp_cyc = 0; rd_cyc = 0;
        for (int n = 0; n < 100 && fs != 0; n++) begin
            drive_cycle(0, 0, fs == 1, fs == 2 || fs == 3);
            if (fs == 1) exp_cyc++;
            if (fs == 2 || fs == 3) rd_cyc++;
            case (fs)
                1: if (ovf5) fs = 2;
                2: if (ovf4) fs = 3;
                3: if (ovf4) fs = 0;
                default: fs = 0;
            endcase
        end
        check("loop_done", fs, 0);
        check("loop_expose", exp_cyc, 3 * TICKS_PER_MS + 1);
        check("loop_read", rd_cyc, 2 * READ_LEN);
        drive_cycle(0, 0, 0, 0);
        check("loop_busy", 32'(busy), 0);

        // Randomized traffic
        r_sc = 0; r_cr = 0;
        for (int k = 0; k < 1500; k++) begin
            if (r_sc) r_sc = ($urandom_range(0, 39) != 0);
            else r_sc = ($urandom_range(0, 11) == 0);
            if (r_cr) r_cr = ($urandom_range(0, 9) != 0);
            else r_cr = ($urandom_range(0, 7) == 0);
            drive_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, r_sc, r_cr);
            if ($urandom_range(0, 199) == 0) apply_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
